// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: requester slot assignment and
// default word geometry.
package bram_port_arbiter_pkg;

   localparam int REQ_IFETCH       = 0;
   localparam int REQ_LSU          = 1;
   localparam int REQ_LOADER       = 2;
   localparam int NREQ_DEFAULT     = 3;
   localparam int WORD_LEN_DEFAULT = 2;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter: per-requester valid/ready
// request channel plus the shared one-cycle response channel.
interface bram_port_arbiter_if
   import bram_port_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEFAULT,
   parameter int DATAW = 32,
   parameter int ADDRW = 12
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_we;
   logic [NREQ*ADDRW-1:0] req_addr;
   logic [NREQ*DATAW-1:0] req_wdata;
   logic [NREQ-1:0]       resp_valid;
   logic [DATAW-1:0]      resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin grant: search starts at ptr and wraps upward, first valid wins.
// ptr advances past the winner only when a grant is issued.
module rr_arbiter #(
   parameter  int NREQ = 3,
   localparam int PTRW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [PTRW-1:0] grant_idx,
   output logic            grant_any
);

   logic [PTRW-1:0] ptr;
   logic [PTRW-1:0] idx;

   // Grants are suppressed during reset so no handshake completes then.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      if (!rst) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = PTRW'((int'(ptr) + k) % NREQ);
            if (!grant_any && req[idx]) begin
               grant_any  = 1'b1;
               grant_idx  = idx;
               grant[idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (grant_idx == PTRW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NREQ requesters: round-robin accept, registered
// issue stage onto the port, response routed to the owner two cycles later.
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter  int NREQ     = NREQ_DEFAULT,
   parameter  int DATAW    = 32,
   parameter  int ADDRW    = 12,
   parameter  int WORD_LEN = WORD_LEN_DEFAULT,
   localparam int MAW      = ADDRW - WORD_LEN,
   localparam int PTRW     = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst,
   bram_port_arbiter_if.slave  bus,
   output logic                mem_en,
   output logic                mem_we,
   output logic [MAW-1:0]      mem_addr,
   output logic [DATAW-1:0]    mem_din,
   input  logic [DATAW-1:0]    mem_dout
);

   logic [NREQ-1:0]  grant;
   logic [PTRW-1:0]  grant_idx;
   logic             grant_any;
   logic             sel_we;
   logic [MAW-1:0]   sel_addr;
   logic [DATAW-1:0] sel_wdata;
   logic             en_q;
   logic             we_q;
   logic [PTRW-1:0]  owner_q;
   logic [NREQ-1:0]  resp_q;
   logic [NREQ-1:0]  resp_vld;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (bus.req_valid),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign bus.req_ready = grant;

   // Byte-offset bits are never routed; misaligned addresses alias the word.
   assign sel_we    = bus.req_we[grant_idx];
   assign sel_addr  = bus.req_addr[grant_idx*ADDRW + WORD_LEN +: MAW];
   assign sel_wdata = bus.req_wdata[grant_idx*DATAW +: DATAW];

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b0;
         we_q     <= 1'b0;
         owner_q  <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         en_q <= grant_any;
         we_q <= grant_any & sel_we;
         if (grant_any) begin
            owner_q  <= grant_idx;
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_q <= '0;
      end else begin
         resp_q <= en_q ? (NREQ'(1) << owner_q) : '0;
      end
   end

   // rst masks the stage outputs in the very cycle it is raised, so a write
   // still sitting in the issue register never reaches the BRAM.
   assign mem_en         = en_q & ~rst;
   assign mem_we         = we_q & ~rst;
   assign resp_vld       = resp_q & {NREQ{~rst}};
   assign bus.resp_valid = resp_vld;
   assign bus.resp_rdata = (|resp_vld) ? mem_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Testbench for bram_port_arbiter: directed scenarios plus a randomized run
// checked against a queue-based transaction model with its own BRAM image.
module tb_bram_port_arbiter;
   import bram_port_arbiter_pkg::*;

   localparam int NREQ  = 3;
   localparam int DATAW = 32;
   localparam int ADDRW = 12;
   localparam int MAW   = 10;

   logic             clk;
   logic             rst;
   logic             mem_en;
   logic             mem_we;
   logic [MAW-1:0]   mem_addr;
   logic [DATAW-1:0] mem_din;
   logic [DATAW-1:0] mem_dout;

   logic             pre_en;
   logic [MAW-1:0]   pre_addr;
   logic [DATAW-1:0] pre_data;
   logic [DATAW-1:0] bram [0:1023];

   int checks;
   int errors;
   int acc_g;

   typedef struct {
      int          acc;
      int          id;
      bit          we;
      logic [9:0]  wa;
      logic [31:0] data;
   } rec_t;

   rec_t        pend[$];
   logic [31:0] ref_mem [0:15];

   bram_port_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW), .ADDRW(ADDRW)) bus ();

   bram_port_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .ADDRW(ADDRW), .WORD_LEN(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first BRAM with a side preload port driven only by the bench.
   always @(posedge clk) begin
      if (pre_en) begin
         bram[pre_addr] <= pre_data;
      end else if (mem_en) begin
         if (mem_we) begin
            bram[mem_addr] <= mem_din;
            mem_dout       <= mem_din;
         end else begin
            mem_dout <= bram[mem_addr];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int i, input bit we, input logic [11:0] a, input logic [31:0] d);
      bus.req_valid[i]               = 1'b1;
      bus.req_we[i]                  = we;
      bus.req_addr[i*ADDRW +: ADDRW] = a;
      bus.req_wdata[i*DATAW +: DATAW] = d;
   endtask

   task automatic preload(input logic [MAW-1:0] w, input logic [31:0] d);
      pre_en   = 1'b1;
      pre_addr = w;
      pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_req(0, 1'b1, 12'h010, 32'h1);
      set_req(1, 1'b0, 12'h020, 32'h2);
      set_req(2, 1'b1, 12'h030, 32'h3);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", bus.req_ready); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_en_we got %b%b want 00", mem_en, mem_we); end
      checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL reset_resp_valid got %b want 000", bus.resp_valid); end
      checks++; if (mem_addr !== 10'd0 || mem_din !== 32'd0 || bus.resp_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_data got %h %h %h want 0 0 0", mem_addr, mem_din, bus.resp_rdata);
      end
      tick();
      clear_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      preload(10'd4, 32'hDEADBEEF);
      set_req(REQ_LSU, 1'b0, 12'h010, 32'h0);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got %b want 010", bus.req_ready); end
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd4) begin
         errors++; $display("FAIL single_issue got en=%b we=%b addr=%0d want en=1 we=0 addr=4", mem_en, mem_we, mem_addr);
      end
      tick();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b010 || bus.resp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_resp got %b %h want 010 deadbeef", bus.resp_valid, bus.resp_rdata);
      end
      tick();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL single_pulse got %b want 000", bus.resp_valid); end
      tick();
   endtask

   task automatic test_write_read();
      set_req(REQ_IFETCH, 1'b1, 12'h020, 32'h12345678);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL wr_ready got %b want 001", bus.req_ready); end
      tick();
      set_req(REQ_IFETCH, 1'b0, 12'h020, 32'h0);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rd_ready got %b want 001", bus.req_ready); end
      checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd8 || mem_din !== 32'h12345678) begin
         errors++; $display("FAIL wr_issue got we=%b addr=%0d din=%h want 1 8 12345678", mem_we, mem_addr, mem_din);
      end
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b001) begin errors++; $display("FAIL wr_ack got %b want 001", bus.resp_valid); end
      tick();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b001 || bus.resp_rdata !== 32'h12345678) begin
         errors++; $display("FAIL raw_resp got %b %h want 001 12345678", bus.resp_valid, bus.resp_rdata);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [31:0] val [0:2];
      logic [2:0]  exp;
      val[0] = 32'hA0A0_0000; val[1] = 32'hB1B1_1111; val[2] = 32'hC2C2_2222;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) preload(MAW'(16 + i), val[i]);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 12'(12'h040 + 4*i), 32'h0);
      for (int c = 0; c < 11; c++) begin
         if (c == 9) clear_inputs();
         @(negedge clk);
         exp = (c < 9) ? 3'(1 << (c % 3)) : 3'b000;
         checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, bus.req_ready, exp); end
         exp = (c >= 2) ? 3'(1 << ((c - 2) % 3)) : 3'b000;
         checks++; if (bus.resp_valid !== exp) begin errors++; $display("FAIL rr_resp c=%0d got %b want %b", c, bus.resp_valid, exp); end
         if (c >= 2) begin
            checks++; if (bus.resp_rdata !== val[(c - 2) % 3]) begin
               errors++; $display("FAIL rr_data c=%0d got %h want %h", c, bus.resp_rdata, val[(c - 2) % 3]);
            end
         end
         tick();
      end
   endtask

   task automatic test_skip();
      logic [2:0] exp [0:2];
      exp[0] = 3'b100; exp[1] = 3'b001; exp[2] = 3'b100;
      set_req(0, 1'b0, 12'h010, 32'h0);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL skip_setup got %b want 001", bus.req_ready); end
      tick();
      clear_inputs();
      tick(); tick();
      set_req(0, 1'b0, 12'h010, 32'h0);
      set_req(2, 1'b0, 12'h044, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (bus.req_ready !== exp[c]) begin errors++; $display("FAIL skip_grant c=%0d got %b want %b", c, bus.req_ready, exp[c]); end
         tick();
      end
      clear_inputs();
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      preload(10'd41, 32'hA5A5A5A5);
      pulse_reset();
      set_req(0, 1'b1, 12'h0A0, 32'h11111111);
      set_req(1, 1'b1, 12'h0A4, 32'h22222222);
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL rm_grant0 got %b want 001", bus.req_ready); end
      tick();
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL rm_grant1 got %b want 010", bus.req_ready); end
      tick();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b000 || mem_we !== 1'b0 || mem_en !== 1'b0 || bus.resp_valid !== 3'b000) begin
         errors++; $display("FAIL rm_in_reset got ready=%b we=%b en=%b resp=%b want all 0", bus.req_ready, mem_we, mem_en, bus.resp_valid);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.req_ready !== 3'b001 || bus.resp_valid !== 3'b000 || mem_en !== 1'b0) begin
         errors++; $display("FAIL rm_after got ready=%b resp=%b en=%b want 001 000 0", bus.req_ready, bus.resp_valid, mem_en);
      end
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b000) begin errors++; $display("FAIL rm_no_resp got %b want 000", bus.resp_valid); end
      tick(); tick(); tick();
      set_req(REQ_LOADER, 1'b0, 12'h0A4, 32'h0);
      tick();
      clear_inputs();
      tick();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b100 || bus.resp_rdata !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL rm_no_commit got %b %h want 100 a5a5a5a5", bus.resp_valid, bus.resp_rdata);
      end
      tick();
   endtask

   task automatic test_misaligned();
      set_req(0, 1'b0, 12'h013, 32'h0);
      tick();
      clear_inputs();
      @(negedge clk);
      checks++; if (mem_addr !== 10'd4) begin errors++; $display("FAIL misaligned_addr got %0d want 4", mem_addr); end
      tick();
      @(negedge clk);
      checks++; if (bus.resp_valid !== 3'b001 || bus.resp_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL misaligned_data got %b %h want 001 deadbeef", bus.resp_valid, bus.resp_rdata);
      end
      tick();
   endtask

   task automatic test_random();
      int          ref_ptr;
      int          eg;
      int          idx;
      logic [2:0]  exp_ready;
      logic [2:0]  exp_resp;
      logic [9:0]  wa;
      rec_t        r;
      rst = 1'b1;
      for (int w = 0; w < 16; w++) begin
         ref_mem[w] = $urandom;
         preload(MAW'(w), ref_mem[w]);
      end
      rst = 1'b0;
      clear_inputs();
      ref_ptr = 0;
      acc_g   = -1;
      pend.delete();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (c >= 392) begin
               bus.req_valid[i] = 1'b0;
            end else if (bus.req_valid[i] && acc_g != i) begin
               if ($urandom_range(7) == 0) bus.req_valid[i] = 1'b0;
            end else begin
               bus.req_valid[i]                = ($urandom_range(9) < 6);
               bus.req_we[i]                   = 1'($urandom_range(1));
               bus.req_addr[i*ADDRW +: ADDRW]  = {6'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
               bus.req_wdata[i*DATAW +: DATAW] = $urandom;
            end
         end
         @(negedge clk);
         eg = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (ref_ptr + k) % NREQ;
            if (eg < 0 && bus.req_valid[idx]) eg = idx;
         end
         exp_ready = '0;
         if (eg >= 0) exp_ready[eg] = 1'b1;
         checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant c=%0d got %b want %b", c, bus.req_ready, exp_ready); end
         if (pend.size() > 0 && pend[$].acc == c - 1) begin
            r = pend[$];
            checks++; if (mem_en !== 1'b1 || mem_we !== r.we || mem_addr !== r.wa || (r.we && mem_din !== r.data)) begin
               errors++; $display("FAIL rnd_issue c=%0d got en=%b we=%b addr=%0d din=%h want 1 %b %0d %h", c, mem_en, mem_we, mem_addr, mem_din, r.we, r.wa, r.data);
            end
         end else begin
            checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
               errors++; $display("FAIL rnd_idle c=%0d got en=%b we=%b want 0 0", c, mem_en, mem_we);
            end
         end
         exp_resp = '0;
         if (pend.size() > 0 && pend[0].acc == c - 2) begin
            r = pend.pop_front();
            exp_resp[r.id] = 1'b1;
            if (!r.we) begin
               checks++; if (bus.resp_rdata !== r.data) begin errors++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, bus.resp_rdata, r.data); end
            end
         end
         checks++; if (bus.resp_valid !== exp_resp) begin errors++; $display("FAIL rnd_resp c=%0d got %b want %b", c, bus.resp_valid, exp_resp); end
         if (eg >= 0) begin
            wa     = bus.req_addr[eg*ADDRW + 2 +: 10];
            r.acc  = c;
            r.id   = eg;
            r.we   = bus.req_we[eg];
            r.wa   = wa;
            if (r.we) begin
               r.data          = bus.req_wdata[eg*DATAW +: DATAW];
               ref_mem[wa[3:0]] = r.data;
            end else begin
               r.data = ref_mem[wa[3:0]];
            end
            pend.push_back(r);
            ref_ptr = (eg + 1) % NREQ;
         end
         acc_g = eg;
         tick();
      end
      checks++; if (pend.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d outstanding want 0", pend.size()); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      pre_en   = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      mem_dout = '0;
      clear_inputs();
      repeat (3) tick();
      test_reset();
      test_single_read();
      test_write_read();
      test_round_robin();
      test_skip();
      test_reset_mid();
      test_misaligned();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
